// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared port constants and types for the mesh switch
// Purpose: port index constants, port count, port index type and a wrap helper.
// Ports: none (package).
package switch_pkg;

    localparam int NUM_PORTS  = 5;
    localparam int PORT_LEFT  = 0;
    localparam int PORT_RIGHT = 1;
    localparam int PORT_UP    = 2;
    localparam int PORT_DOWN  = 3;
    localparam int PORT_PE    = 4;

    typedef logic [2:0] port_idx_t;

    // Successor of a port index, wrapping PE back to left.
    function automatic port_idx_t next_port(input port_idx_t p);
        return (p == 3'd4) ? 3'd0 : p + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arb5.sv
// rtl/rr_arb5.sv - five-requester round-robin arbiter with pointer register
// Purpose: grants the first requester at or after the pointer (ascending, wrap 4->0);
//          the pointer moves past the winner on a grant and holds otherwise.
// Ports:
//   clk, i_reset_n  clock, asynchronous active-low reset (pointer -> 0)
//   i_en            arbitration enabled (output can accept a packet)
//   i_req[4:0]      request per input port
//   o_gnt_valid     a grant is issued this cycle (combinational)
//   o_gnt_idx       index of the granted input (combinational)
module rr_arb5
    import switch_pkg::*;
(
    input  logic      clk,
    input  logic      i_reset_n,
    input  logic      i_en,
    input  logic [4:0] i_req,
    output logic      o_gnt_valid,
    output port_idx_t o_gnt_idx
);

    port_idx_t  ptr_q;
    port_idx_t  ptr_d;
    logic       found;
    port_idx_t  win;
    logic [3:0] sum;
    port_idx_t  cand;

    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < 5; k++) begin
            sum = {1'b0, ptr_q} + 4'(k);
            if (sum >= 4'd5) begin
                sum = sum - 4'd5;
            end
            cand = sum[2:0];
            if (i_en && !found && i_req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        ptr_d = found ? next_port(win) : ptr_q;
    end

    assign o_gnt_valid = found;
    assign o_gnt_idx   = win;

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/switch_xy_arbiter.sv
// rtl/switch_xy_arbiter.sv - XY routing and per-output round-robin scheduling for the 5-port switch
// Purpose: routes each input FIFO head by XY order, arbitrates each output independently,
//          and issues pop (stage G) then push + crossbar select (stage W).
// Optional feature macro: SWITCH_ARB_STATS_EN adds per-output saturating push counters.
// Ports:
//   clk, i_reset_n  clock, asynchronous active-low reset
//   i_req_valid     input FIFO p non-empty
//   i_req_dest      head destination {x,y} per input, slice p at [p*(X_W+Y_W) +: X_W+Y_W]
//   i_out_ready     output FIFO q has at least 2 free entries
//   o_rd_en         pop input FIFO p (one-cycle pulse)
//   o_wr_en         push output FIFO q
//   o_sel           crossbar source for output q at [q*3 +: 3], valid with o_wr_en[q]
//   o_busy          any grant or write in flight
//   o_grant_cnt     (SWITCH_ARB_STATS_EN only) 16-bit push counter per output
module switch_xy_arbiter #(
    parameter int NUM_PORTS = 5,
    parameter int XNO       = 4,
    parameter int YNO       = 4,
    parameter int X         = 0,
    parameter int Y         = 0,
    parameter int X_W       = $clog2(XNO),
    parameter int Y_W       = $clog2(YNO)
) (
    input  logic                           clk,
    input  logic                           i_reset_n,
    input  logic [NUM_PORTS-1:0]           i_req_valid,
    input  logic [NUM_PORTS*(X_W+Y_W)-1:0] i_req_dest,
    input  logic [NUM_PORTS-1:0]           i_out_ready,
    output logic [NUM_PORTS-1:0]           o_rd_en,
    output logic [NUM_PORTS-1:0]           o_wr_en,
    output logic [NUM_PORTS*3-1:0]         o_sel,
    output logic                           o_busy
`ifdef SWITCH_ARB_STATS_EN
    ,
    output logic [NUM_PORTS*16-1:0]        o_grant_cnt
`endif
);

    import switch_pkg::port_idx_t;
    import switch_pkg::PORT_LEFT;
    import switch_pkg::PORT_RIGHT;
    import switch_pkg::PORT_UP;
    import switch_pkg::PORT_DOWN;
    import switch_pkg::PORT_PE;

    localparam int DW = X_W + Y_W;
    localparam logic [X_W-1:0] X_C = X_W'(X);
    localparam logic [Y_W-1:0] Y_C = Y_W'(Y);

    function automatic port_idx_t route(input logic [X_W-1:0] dx, input logic [Y_W-1:0] dy);
        if (dx > X_C)      return port_idx_t'(PORT_RIGHT);
        else if (dx < X_C) return port_idx_t'(PORT_LEFT);
        else if (dy > Y_C) return port_idx_t'(PORT_UP);
        else if (dy < Y_C) return port_idx_t'(PORT_DOWN);
        else               return port_idx_t'(PORT_PE);
    endfunction

    // Stage G: registered grants; rd_en_q doubles as the mask because the
    // FIFO valid/head still show the popped packet during this cycle.
    logic [NUM_PORTS-1:0]   rd_en_q, rd_en_d;
    logic [NUM_PORTS-1:0]   g_valid_q, g_valid_d;
    port_idx_t              g_idx_q [NUM_PORTS];
    port_idx_t              g_idx_d [NUM_PORTS];
    // Stage W: push and crossbar select.
    logic [NUM_PORTS-1:0]   wr_en_q, wr_en_d;
    logic [NUM_PORTS*3-1:0] sel_q, sel_d;

    logic [NUM_PORTS-1:0]   req [NUM_PORTS];
    logic [NUM_PORTS-1:0]   gnt_valid;
    port_idx_t              gnt_idx [NUM_PORTS];
    port_idx_t              rt;
    logic [DW-1:0]          dst;

    always_comb begin
        rt  = '0;
        dst = '0;
        for (int q = 0; q < NUM_PORTS; q++) begin
            req[q] = '0;
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            dst = i_req_dest[p*DW +: DW];
            rt  = route(dst[DW-1 -: X_W], dst[Y_W-1:0]);
            for (int q = 0; q < NUM_PORTS; q++) begin
                req[q][p] = i_req_valid[p] && (rt == port_idx_t'(q)) && !rd_en_q[p];
            end
        end
    end

    for (genvar gq = 0; gq < NUM_PORTS; gq++) begin : g_arb
        rr_arb5 u_arb (
            .clk         (clk),
            .i_reset_n   (i_reset_n),
            .i_en        (i_out_ready[gq]),
            .i_req       (req[gq]),
            .o_gnt_valid (gnt_valid[gq]),
            .o_gnt_idx   (gnt_idx[gq])
        );
    end

    always_comb begin
        rd_en_d   = '0;
        g_valid_d = gnt_valid;
        wr_en_d   = g_valid_q;
        sel_d     = '0;
        for (int q = 0; q < NUM_PORTS; q++) begin
            g_idx_d[q] = gnt_idx[q];
            if (gnt_valid[q]) begin
                rd_en_d[gnt_idx[q]] = 1'b1;
            end
            if (g_valid_q[q]) begin
                sel_d[q*3 +: 3] = g_idx_q[q];
            end
        end
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_en_q   <= '0;
            g_valid_q <= '0;
            wr_en_q   <= '0;
            sel_q     <= '0;
            for (int q = 0; q < NUM_PORTS; q++) begin
                g_idx_q[q] <= '0;
            end
        end else begin
            rd_en_q   <= rd_en_d;
            g_valid_q <= g_valid_d;
            wr_en_q   <= wr_en_d;
            sel_q     <= sel_d;
            for (int q = 0; q < NUM_PORTS; q++) begin
                g_idx_q[q] <= g_idx_d[q];
            end
        end
    end

    assign o_rd_en = rd_en_q;
    assign o_wr_en = wr_en_q;
    assign o_sel   = sel_q;
    assign o_busy  = (|g_valid_q) || (|wr_en_q);

`ifdef SWITCH_ARB_STATS_EN
    logic [NUM_PORTS*16-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int q = 0; q < NUM_PORTS; q++) begin
            if (wr_en_q[q] && (cnt_q[q*16 +: 16] != 16'hFFFF)) begin
                cnt_d[q*16 +: 16] = cnt_q[q*16 +: 16] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_switch_xy_arbiter.sv
// tb/tb_switch_xy_arbiter.sv - directed self-checking bench for switch_xy_arbiter at X=1,Y=1
module tb_switch_xy_arbiter;

    localparam int NP = 5;
    localparam int DW = 4;

    logic             clk = 1'b0;
    logic             i_reset_n;
    logic [NP-1:0]    i_req_valid;
    logic [NP*DW-1:0] i_req_dest;
    logic [NP-1:0]    i_out_ready;
    logic [NP-1:0]    o_rd_en;
    logic [NP-1:0]    o_wr_en;
    logic [NP*3-1:0]  o_sel;
    logic             o_busy;
`ifdef SWITCH_ARB_STATS_EN
    logic [NP*16-1:0] o_grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    switch_xy_arbiter #(
        .NUM_PORTS (5),
        .XNO       (4),
        .YNO       (4),
        .X         (1),
        .Y         (1)
    ) dut (
        .clk         (clk),
        .i_reset_n   (i_reset_n),
        .i_req_valid (i_req_valid),
        .i_req_dest  (i_req_dest),
        .i_out_ready (i_out_ready),
        .o_rd_en     (o_rd_en),
        .o_wr_en     (o_wr_en),
        .o_sel       (o_sel),
        .o_busy      (o_busy)
`ifdef SWITCH_ARB_STATS_EN
        ,
        .o_grant_cnt (o_grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic set_dest(input int p, input int x, input int y);
        i_req_dest[p*DW +: DW] = {2'(x), 2'(y)};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset_n   = 1'b0;
        i_req_valid = '0;
        i_req_dest  = '0;
        i_out_ready = '1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (o_rd_en !== 5'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected %b", o_rd_en, 5'b0); end
        checks++; if (o_wr_en !== 5'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected %b", o_wr_en, 5'b0); end
        checks++; if (o_sel !== 15'b0) begin errors++; $display("FAIL reset_sel: got %h expected %h", o_sel, 15'b0); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected %b", o_busy, 1'b0); end
        @(negedge clk);
        i_reset_n = 1'b1;
        step();
    endtask

    task automatic test_single_route();
        set_dest(4, 3, 1);
        i_req_valid = 5'b10000;
        step();
        i_req_valid = '0;
        checks++; if (o_rd_en !== 5'b10000) begin errors++; $display("FAIL single_rd_en: got %b expected %b", o_rd_en, 5'b10000); end
        checks++; if (o_wr_en !== 5'b00000) begin errors++; $display("FAIL single_wr_early: got %b expected %b", o_wr_en, 5'b0); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected %b", o_busy, 1'b1); end
        step();
        checks++; if (o_wr_en !== 5'b00010) begin errors++; $display("FAIL single_wr_en: got %b expected %b", o_wr_en, 5'b00010); end
        checks++; if (o_sel[1*3 +: 3] !== 3'd4) begin errors++; $display("FAIL single_sel1: got %0d expected %0d", o_sel[1*3 +: 3], 4); end
        checks++; if (o_rd_en !== 5'b00000) begin errors++; $display("FAIL single_rd_pulse: got %b expected %b", o_rd_en, 5'b0); end
        step();
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b expected %b", o_busy, 1'b0); end
    endtask

    task automatic test_pe_round_robin();
        logic [4:0] exp_rd [4];
        logic [2:0] exp_sel [4];
        exp_rd[0] = 5'b00001; exp_rd[1] = 5'b00100; exp_rd[2] = 5'b01000; exp_rd[3] = 5'b00001;
        exp_sel[0] = 3'd0; exp_sel[1] = 3'd2; exp_sel[2] = 3'd3; exp_sel[3] = 3'd0;
        set_dest(0, 1, 1);
        set_dest(2, 1, 1);
        set_dest(3, 1, 1);
        i_req_valid = 5'b01101;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (o_rd_en !== exp_rd[k]) begin errors++; $display("FAIL pe_rr_rd_en[%0d]: got %b expected %b", k, o_rd_en, exp_rd[k]); end
            if (k >= 1) begin
                checks++; if (o_wr_en !== 5'b10000) begin errors++; $display("FAIL pe_rr_wr_en[%0d]: got %b expected %b", k, o_wr_en, 5'b10000); end
                checks++; if (o_sel[4*3 +: 3] !== exp_sel[k-1]) begin errors++; $display("FAIL pe_rr_sel[%0d]: got %0d expected %0d", k, o_sel[4*3 +: 3], exp_sel[k-1]); end
            end
        end
        i_req_valid = '0;
        step();
        checks++; if (o_wr_en !== 5'b10000) begin errors++; $display("FAIL pe_rr_last_wr: got %b expected %b", o_wr_en, 5'b10000); end
        checks++; if (o_sel[4*3 +: 3] !== exp_sel[3]) begin errors++; $display("FAIL pe_rr_last_sel: got %0d expected %0d", o_sel[4*3 +: 3], exp_sel[3]); end
        checks++; if (o_rd_en !== 5'b00000) begin errors++; $display("FAIL pe_rr_drain_rd: got %b expected %b", o_rd_en, 5'b0); end
        step();
    endtask

    task automatic test_five_outputs();
        set_dest(0, 3, 1);
        set_dest(1, 0, 1);
        set_dest(2, 1, 3);
        set_dest(3, 1, 0);
        set_dest(4, 1, 1);
        i_req_valid = 5'b11111;
        step();
        i_req_valid = '0;
        checks++; if (o_rd_en !== 5'b11111) begin errors++; $display("FAIL five_rd_en: got %b expected %b", o_rd_en, 5'b11111); end
        step();
        checks++; if (o_wr_en !== 5'b11111) begin errors++; $display("FAIL five_wr_en: got %b expected %b", o_wr_en, 5'b11111); end
        checks++; if (o_sel !== 15'b100_011_010_000_001) begin errors++; $display("FAIL five_sel: got %b expected %b", o_sel, 15'b100_011_010_000_001); end
        step();
    endtask

    task automatic test_reset_mid_flight();
        set_dest(3, 1, 1);
        i_req_valid = 5'b01000;
        step();
        i_req_valid = '0;
        checks++; if (o_rd_en !== 5'b01000) begin errors++; $display("FAIL rst_pre_rd_en: got %b expected %b", o_rd_en, 5'b01000); end
        i_reset_n = 1'b0;
        #1;
        checks++; if (o_rd_en !== 5'b0) begin errors++; $display("FAIL rst_async_rd_en: got %b expected %b", o_rd_en, 5'b0); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b expected %b", o_busy, 1'b0); end
        step();
        checks++; if (o_wr_en !== 5'b0) begin errors++; $display("FAIL rst_no_push: got %b expected %b", o_wr_en, 5'b0); end
        checks++; if (o_sel !== 15'b0) begin errors++; $display("FAIL rst_sel: got %h expected %h", o_sel, 15'b0); end
        @(negedge clk);
        i_reset_n = 1'b1;
        step();
        checks++; if (o_wr_en !== 5'b0) begin errors++; $display("FAIL rst_release_wr: got %b expected %b", o_wr_en, 5'b0); end
        set_dest(2, 1, 1);
        set_dest(4, 1, 1);
        i_req_valid = 5'b10100;
        step();
        i_req_valid = '0;
        checks++; if (o_rd_en !== 5'b00100) begin errors++; $display("FAIL rst_ptr_zero_rd: got %b expected %b", o_rd_en, 5'b00100); end
        step();
        checks++; if (o_sel[4*3 +: 3] !== 3'd2) begin errors++; $display("FAIL rst_ptr_zero_sel: got %0d expected %0d", o_sel[4*3 +: 3], 2); end
        step();
    endtask

    task automatic test_stall();
        set_dest(1, 0, 1);
        set_dest(3, 0, 1);
        i_out_ready = 5'b11110;
        i_req_valid = 5'b01010;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (o_rd_en !== 5'b0) begin errors++; $display("FAIL stall_rd_en[%0d]: got %b expected %b", k, o_rd_en, 5'b0); end
        end
        i_out_ready = 5'b11111;
        step();
        checks++; if (o_rd_en !== 5'b00010) begin errors++; $display("FAIL stall_first_grant: got %b expected %b", o_rd_en, 5'b00010); end
        i_req_valid = 5'b01000;
        step();
        checks++; if (o_rd_en !== 5'b01000) begin errors++; $display("FAIL stall_second_grant: got %b expected %b", o_rd_en, 5'b01000); end
        checks++; if (o_wr_en !== 5'b00001) begin errors++; $display("FAIL stall_wr0: got %b expected %b", o_wr_en, 5'b00001); end
        checks++; if (o_sel[2:0] !== 3'd1) begin errors++; $display("FAIL stall_sel0_a: got %0d expected %0d", o_sel[2:0], 1); end
        i_req_valid = '0;
        step();
        checks++; if (o_sel[2:0] !== 3'd3) begin errors++; $display("FAIL stall_sel0_b: got %0d expected %0d", o_sel[2:0], 3); end
        step();
    endtask

`ifdef SWITCH_ARB_STATS_EN
    task automatic test_stats_saturate();
        set_dest(0, 1, 2);
        set_dest(1, 1, 2);
        i_req_valid = 5'b00011;
        repeat (70000) @(posedge clk);
        #1;
        i_req_valid = '0;
        repeat (3) step();
        checks++; if (o_grant_cnt[2*16 +: 16] !== 16'hFFFF) begin errors++; $display("FAIL stats_cnt2: got %h expected %h", o_grant_cnt[2*16 +: 16], 16'hFFFF); end
        checks++; if (o_grant_cnt[3*16 +: 16] !== 16'd0) begin errors++; $display("FAIL stats_cnt3: got %h expected %h", o_grant_cnt[3*16 +: 16], 16'd0); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_route();
        test_pe_round_robin();
        test_five_outputs();
        test_reset_mid_flight();
        test_stall();
`ifdef SWITCH_ARB_STATS_EN
        test_stats_saturate();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_xy_arbiter.md
# switch_xy_arbiter

Scheduling controller for the 5-port mesh switch. It takes the head-of-FIFO valid and destination coordinates of the five input FIFOs (left, right, up, down, PE) and computes the XY route for each. It then runs one round-robin arbiter per output FIFO and issues input-pop, output-push and crossbar-select controls. All five outputs can be served concurrently, so it replaces the serial one-packet-at-a-time FSM in the switch.

## Interface
Parameters:
- NUM_PORTS, 5, port count; index 0 left, 1 right, 2 up, 3 down, 4 PE
- XNO, 4, switches in x; X_W = $clog2(XNO)
- YNO, 4, switches in y; Y_W = $clog2(YNO)
- X, 0, this switch's x coordinate
- Y, 0, this switch's y coordinate

Ports:
- clk  in  1  single clock, rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_req_valid  in  NUM_PORTS  input FIFO p is non-empty (o_rd_valid of that FIFO)
- i_req_dest  in  NUM_PORTS*(X_W+Y_W)  head-packet destination of FIFO p, {x,y}; slice p = bits [p*(X_W+Y_W) +: X_W+Y_W]
- i_out_ready  in  NUM_PORTS  output FIFO q has at least 2 free entries
- o_rd_en  out  NUM_PORTS  pop input FIFO p, one-cycle pulse
- o_wr_en  out  NUM_PORTS  push output FIFO q
- o_sel  out  NUM_PORTS*3  crossbar source index for output q, valid when o_wr_en[q]=1
- o_busy  out  1  any grant or write in flight

## Operation
- Route (combinational, per input p), with dest = (dx,dy):
  - dx>X → 1
  - dx<X → 0
  - otherwise dy>Y → 2
  - dy<Y → 3
  - otherwise → 4 (PE)
- Request matrix: req[q][p] = i_req_valid[p] & route(p)==q & ~mask[p].
- mask[p] = 1 in the cycle after p was granted, because the FIFO valid and head data lag the pop by one cycle.
- Per-output arbiter q:
  - Eligible only if i_out_ready[q].
  - Picks the first requesting p starting from ptr[q], searching ascending and wrapping 4→0.
  - On grant: ptr[q] ← (p+1) mod 5.
  - Without a grant, ptr[q] holds.
- One input can target only one output, so grants are conflict-free by construction. At most 5 grants per cycle.
- Pipeline per grant:
  - Stage G: registered grant, drives o_rd_en[p].
  - Stage W: o_wr_en[q]=1 and o_sel[q]=p. Input FIFO read data is valid this cycle and is muxed by the switch datapath.
- Reset values: o_rd_en=0, o_wr_en=0, o_sel=0, o_busy=0, all ptr=0, mask=0.

## Timing
- Cycle n: req sampled.
- Cycle n+1: o_rd_en[p]=1.
- Cycle n+2: o_wr_en[q]=1, o_sel[q]=p.
- Latency from request to push is 2 cycles.
- Throughput:
  - Each output: 1 grant/cycle.
  - Each input: 1 grant per 2 cycles, because of the mask.
- i_out_ready requires 2 free entries so that the grant in stage G plus the write in stage W cannot overflow the output FIFO. i_out_ready is not re-checked at stage W.
- i_req_valid dropping in the cycle of a grant is illegal. FIFOs only lose valid via pop.
- Asynchronous reset mid-operation clears all in-flight stages immediately. No partial push occurs after reset release.
- Destination outside the mesh (dx ≥ XNO, or dy ≥ YNO) still routes per the comparisons above. No error path.

## Configuration
- SWITCH_ARB_STATS_EN defined:
  - Adds output o_grant_cnt, NUM_PORTS*16 bits: one counter per output.
  - Each counter increments on o_wr_en[q] and saturates at 16'hFFFF.
  - Counters are cleared by reset.
- SWITCH_ARB_STATS_EN undefined: the port and the counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package switch_pkg holds:
  - port index constants PORT_LEFT=0, PORT_RIGHT=1, PORT_UP=2, PORT_DOWN=3, PORT_PE=4
  - NUM_PORTS
  - the 3-bit port_idx typedef
- One sub-module, rr_arb5: a 5-requester round-robin arbiter with pointer register, instantiated once per output.
- Route compute and pipeline registers live in the top level.

## Test plan
- X=1,Y=1; input 4 valid, dest (3,1); out_ready all 1 → o_rd_en=5'b10000 at n+1; o_wr_en=5'b00010, o_sel[1]=4 at n+2.
- Inputs 0,2,3 all valid, all dest (1,1) (PE), held valid → grants to PE in order 0,2,3,0; ptr[4]=1 after the first grant; one grant per cycle to PE, with no input granted twice in adjacent cycles.
- Five inputs routed to five distinct outputs → all five o_wr_en set in the same cycle with correct o_sel.
- Input 1 → output 0 with i_out_ready[0]=0 for 3 cycles, then 1 → no o_rd_en while low; grant one cycle after ready rises; ptr unchanged while stalled.
- Assert i_reset_n=0 the cycle after a grant → o_wr_en stays 0; all outputs 0; after release, the first arbitration starts from ptr=0.
- With SWITCH_ARB_STATS_EN: 70000 pushes to output 2 → o_grant_cnt[2] reads 16'hFFFF.
